// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through byte FIFO, with sticky
// framing/overrun flags and registered RTS flow control.
module uart_rx_fifo #(
  parameter int CLK_DIV       = 16,
  parameter int FIFO_AW       = 4,
  parameter int RTS_THRESHOLD = 12
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic       rts,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  input  logic       rd_ready,
  output logic       framing_err,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int                CW     = $clog2(CLK_DIV);
  localparam int                DEPTH  = 1 << FIFO_AW;
  localparam logic [CW-1:0]     HALF   = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]     LAST   = CW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]  THRESH = (FIFO_AW + 1)'(RTS_THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t             state;
  logic               rx_m;
  logic               rx_s;
  logic [CW-1:0]      cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic stop_sample;
  logic pop;
  logic accepting;
  logic push;
  logic frame_bad;
  logic drop;

  // Handshake: a byte transfers on any cycle where rd_valid and rd_ready are
  // both high; rd_data is stable while rd_valid is high and not popped.
  assign rd_valid    = (count != '0);
  assign rd_data     = rd_valid ? mem[rd_ptr] : 8'h00;
  assign pop         = rd_valid && rd_ready;
  assign accepting   = !count[FIFO_AW] || pop;
  assign stop_sample = (state == S_STOP) && (cnt == LAST);
  assign push        = stop_sample && rx_s && accepting;
  assign drop        = stop_sample && rx_s && !accepting;
  assign frame_bad   = stop_sample && !rx_s;

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          // Leave at mid stop bit so the next start edge is caught early.
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A set event in the same cycle as clr_err leaves the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rts         <= 1'b1;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rts <= (count >= THRESH);
      if (frame_bad)    framing_err <= 1'b1;
      else if (clr_err) framing_err <= 1'b0;
      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule
